// File: rtl/ula_control_fsm.sv
// ula_control_fsm: multicycle control unit for the ALU datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, decodes opcode/funct into the ALU op
// and operand selects, and raises a sticky trap on illegal instructions or
// on a memory access that never completes.
// Optional build macro ULA_CTRL_PERF_EN adds o_retired_count (pc_write count).
//
// state  | meaning
// FETCH  | wait for instr_valid, load IR
// DECODE | register ALU op/selects and instruction class
// EXEC   | ALU cycle; branches resolve and update the PC here
// MEM    | hold mem_read/mem_write until mem_ready or timeout
// WB     | register write and PC+4
// TRAP   | sticky error, only reset leaves it
`timescale 1ns/1ps
module ula_control_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_instr_valid,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero_flag,
  input  logic       i_mem_ready,
  output logic       o_ir_write,
  output logic [4:0] o_ula_op,
  output logic [1:0] o_ula_in1_sel,
  output logic       o_ula_in2_sel,
  output logic       o_reg_write,
  output logic       o_reg_dst_rd,
  output logic       o_mem_to_reg,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_pc_write,
  output logic       o_pc_src,
  output logic       o_trap,
  output logic [1:0] o_trap_cause
`ifdef ULA_CTRL_PERF_EN
  ,
  output logic [31:0] o_retired_count
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_BNE} cls_t;

  localparam logic [TIMEOUT_W-1:0] LP_TIMEOUT = TIMEOUT_W'(MEM_TIMEOUT);
  localparam bit LP_TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t               r_state, w_state_next;
  cls_t                 r_cls, w_dec_cls;
  logic [4:0]           r_ula_op, w_dec_op;
  logic [1:0]           r_in1_sel, w_dec_in1;
  logic                 r_in2_sel, w_dec_in2;
  logic                 r_reg_dst_rd, w_dec_rd;
  logic                 w_dec_ok;
  logic [1:0]           r_trap_cause;
  logic [TIMEOUT_W-1:0] r_wait_cnt, w_wait_inc;
  logic                 w_mem_timeout;

  assign w_wait_inc    = r_wait_cnt + 1'b1;
  assign w_mem_timeout = LP_TIMEOUT_EN && (w_wait_inc == LP_TIMEOUT);

  // Instruction decode from the live opcode/funct (stable during DECODE).
  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_op  = 5'd0;
    w_dec_in1 = 2'd0;
    w_dec_in2 = 1'b0;
    w_dec_cls = C_ALU;
    w_dec_rd  = 1'b0;
    if (i_opcode == 6'h00) begin
      w_dec_rd = 1'b1;
      case (i_funct)
        6'h00: begin w_dec_op = 5'd0; w_dec_in2 = 1'b1; end
        6'h02: begin w_dec_op = 5'd1; w_dec_in2 = 1'b1; end
        6'h03: begin w_dec_op = 5'd2; w_dec_in2 = 1'b1; end
        6'h04: w_dec_op = 5'd3;
        6'h06: w_dec_op = 5'd4;
        6'h07: w_dec_op = 5'd5;
        6'h20, 6'h21: w_dec_op = 5'd6;
        6'h22, 6'h23: w_dec_op = 5'd7;
        6'h24: w_dec_op = 5'd8;
        6'h25: w_dec_op = 5'd9;
        6'h26: w_dec_op = 5'd10;
        6'h27: w_dec_op = 5'd11;
        6'h2A: w_dec_op = 5'd12;
        6'h2B: w_dec_op = 5'd13;
        default: w_dec_ok = 1'b0;
      endcase
    end else begin
      case (i_opcode)
        6'h08, 6'h09: begin w_dec_op = 5'd6;  w_dec_in1 = 2'd1; end
        6'h0A: begin w_dec_op = 5'd12; w_dec_in1 = 2'd1; end
        6'h0B: begin w_dec_op = 5'd13; w_dec_in1 = 2'd1; end
        6'h0C: begin w_dec_op = 5'd8;  w_dec_in1 = 2'd2; end
        6'h0D: begin w_dec_op = 5'd9;  w_dec_in1 = 2'd2; end
        6'h0E: begin w_dec_op = 5'd10; w_dec_in1 = 2'd2; end
        6'h0F: begin w_dec_op = 5'd14; w_dec_in1 = 2'd2; end
        6'h23: begin w_dec_op = 5'd6;  w_dec_in1 = 2'd1; w_dec_cls = C_LW; end
        6'h2B: begin w_dec_op = 5'd6;  w_dec_in1 = 2'd1; w_dec_cls = C_SW; end
        6'h04: begin w_dec_op = 5'd7;  w_dec_cls = C_BEQ; end
        6'h05: begin w_dec_op = 5'd7;  w_dec_cls = C_BNE; end
        default: w_dec_ok = 1'b0;
      endcase
    end
  end

  // State register, decode registers, trap cause and MEM wait counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_cls        <= C_ALU;
      r_ula_op     <= 5'd0;
      r_in1_sel    <= 2'd0;
      r_in2_sel    <= 1'b0;
      r_reg_dst_rd <= 1'b0;
      r_trap_cause <= 2'd0;
      r_wait_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        if (w_dec_ok) begin
          r_cls        <= w_dec_cls;
          r_ula_op     <= w_dec_op;
          r_in1_sel    <= w_dec_in1;
          r_in2_sel    <= w_dec_in2;
          r_reg_dst_rd <= w_dec_rd;
        end else begin
          r_trap_cause <= 2'b01;
        end
      end
      if (r_state == S_EXEC) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_MEM && !i_mem_ready) begin
        r_wait_cnt <= w_wait_inc;
        if (w_mem_timeout) r_trap_cause <= 2'b10;
      end
    end
  end

  // Next state and strobes; everything held low while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_trap       = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_ir_write = i_instr_valid;
          if (i_instr_valid) w_state_next = S_DECODE;
        end
        S_DECODE: w_state_next = w_dec_ok ? S_EXEC : S_TRAP;
        S_EXEC: begin
          case (r_cls)
            C_LW, C_SW: w_state_next = S_MEM;
            C_BEQ: begin
              o_pc_write   = 1'b1;
              o_pc_src     = i_zero_flag;
              w_state_next = S_FETCH;
            end
            C_BNE: begin
              o_pc_write   = 1'b1;
              o_pc_src     = !i_zero_flag;
              w_state_next = S_FETCH;
            end
            default: w_state_next = S_WB;
          endcase
        end
        S_MEM: begin
          o_mem_read  = (r_cls == C_LW);
          o_mem_write = (r_cls == C_SW);
          if (i_mem_ready) begin
            if (r_cls == C_LW) begin
              w_state_next = S_WB;
            end else begin
              o_pc_write   = 1'b1;
              w_state_next = S_FETCH;
            end
          end else if (w_mem_timeout) begin
            w_state_next = S_TRAP;
          end
        end
        S_WB: begin
          o_reg_write  = 1'b1;
          o_pc_write   = 1'b1;
          o_mem_to_reg = (r_cls == C_LW);
          w_state_next = S_FETCH;
        end
        S_TRAP:  o_trap = 1'b1;
        default: w_state_next = S_FETCH;
      endcase
    end
  end

  assign o_ula_op      = r_ula_op;
  assign o_ula_in1_sel = r_in1_sel;
  assign o_ula_in2_sel = r_in2_sel;
  assign o_reg_dst_rd  = r_reg_dst_rd;
  assign o_trap_cause  = r_trap_cause;

`ifdef ULA_CTRL_PERF_EN
  logic [31:0] r_retired_count;

  // Count every PC update; wraps naturally at 32 bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_retired_count <= 32'd0;
    else if (o_pc_write) r_retired_count <= r_retired_count + 32'd1;
  end

  assign o_retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_ula_control_fsm.sv
// Testbench for ula_control_fsm: directed cases then randomized instructions
// checked cycle by cycle against a table-driven instruction model.
`timescale 1ns/1ps
module tb_ula_control_fsm;

  localparam int TO = 6;
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic       ir_write, ula_in2_sel, reg_write, reg_dst_rd, mem_to_reg;
  logic       mem_read, mem_write, pc_write, pc_src, trap;
  logic [4:0] ula_op;
  logic [1:0] ula_in1_sel, trap_cause;
`ifdef ULA_CTRL_PERF_EN
  logic [31:0] retired_count;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned exp_retired = 0;

  always #5 clk = ~clk;

  ula_control_fsm #(.MEM_TIMEOUT(TO), .TIMEOUT_W(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_instr_valid(instr_valid),
    .i_opcode(opcode), .i_funct(funct), .i_zero_flag(zero_flag),
    .i_mem_ready(mem_ready), .o_ir_write(ir_write), .o_ula_op(ula_op),
    .o_ula_in1_sel(ula_in1_sel), .o_ula_in2_sel(ula_in2_sel),
    .o_reg_write(reg_write), .o_reg_dst_rd(reg_dst_rd),
    .o_mem_to_reg(mem_to_reg), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_pc_write(pc_write), .o_pc_src(pc_src),
    .o_trap(trap), .o_trap_cause(trap_cause)
`ifdef ULA_CTRL_PERF_EN
    , .o_retired_count(retired_count)
`endif
  );

  // Spec tables: R-type funct -> (op, in2); I-type opcode -> (op, in1, class)
  int r_fn_list[16]  = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h20, 'h21,
                         'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
  int r_op_list[16]  = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 7, 8, 9, 10, 11, 12, 13};
  int r_in2_list[16] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int i_opc_list[12] = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F,
                         'h23, 'h2B, 'h04, 'h05};
  int i_op_list[12]  = '{6, 6, 12, 13, 8, 9, 10, 14, 6, 6, 7, 7};
  int i_in1_list[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 0, 0};
  int i_cls_list[12] = '{K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU,
                         K_ALU, K_LW, K_SW, K_BEQ, K_BNE};

  int r_op[64], r_in2[64], i_op[64], i_in1[64], i_cls[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {25'd0, ir_write, reg_write, pc_write, pc_src, mem_read, mem_write, mem_to_reg};
  endfunction

  function automatic logic [31:0] stb(input bit ir, input bit rw, input bit pw, input bit ps,
                                      input bit mr, input bit mw, input bit mtr);
    return {25'd0, ir, rw, pw, ps, mr, mw, mtr};
  endfunction

  function automatic logic [31:0] all_outs();
    return {13'd0, ir_write, ula_op, ula_in1_sel, ula_in2_sel, reg_write, reg_dst_rd,
            mem_to_reg, mem_read, mem_write, pc_write, pc_src, trap, trap_cause};
  endfunction

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn, output bit ok,
                                     output int uop, output int in1, output int in2,
                                     output int cls, output int rd);
    if (op == 6'h00) begin
      ok = (r_op[fn] >= 0); uop = r_op[fn]; in1 = 0; in2 = r_in2[fn]; cls = K_ALU; rd = 1;
    end else begin
      ok = (i_op[op] >= 0); uop = i_op[op]; in1 = i_in1[op]; in2 = 0; cls = i_cls[op]; rd = 0;
    end
  endfunction

  task automatic chk_retired();
`ifdef ULA_CTRL_PERF_EN
    chk("retired", retired_count, exp_retired);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0; mem_ready = 1'b0;
    reset = 1'b1;
    #1 chk("rst_outs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
    #1 chk_retired();
  endtask

  task automatic hold_trap(input int cause);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("trap", {31'd0, trap}, 32'd1);
    chk("trap_cause", {30'd0, trap_cause}, cause);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instr_valid = 1'b1; mem_ready = 1'b1;
      #1 chk("trap_hold", {strobes()[31:0] | {31'd0, ~trap}}, 32'd0);
      chk("trap_cause_hold", {30'd0, trap_cause}, cause);
    end
    do_reset();
  endtask

  // One instruction, checked every cycle. wait_n < 0 means memory never responds.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wait_n,
                           input bit zf);
    bit ok, rdy, done;
    int uop, in1, in2, cls, rd, n_rd;
    ref_decode(op, fn, ok, uop, in1, in2, cls, rd);
    @(negedge clk);
    instr_valid = 1'b1; opcode = op; funct = fn; mem_ready = 1'b0; zero_flag = ~zf;
    #1 chk("fetch", strobes(), stb(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    instr_valid = 1'b0;
    #1 chk("decode", strobes(), 32'd0);
    if (!ok) begin
      hold_trap(1);
      return;
    end
    @(negedge clk);
    zero_flag = zf;
    #1 chk("ula_op", {27'd0, ula_op}, uop);
    chk("in1_sel", {30'd0, ula_in1_sel}, in1);
    chk("in2_sel", {31'd0, ula_in2_sel}, in2);
    if (cls == K_BEQ || cls == K_BNE) begin
      chk("exec_branch", strobes(), stb(0, 0, 1, (cls == K_BEQ) ? zf : !zf, 0, 0, 0));
      exp_retired++;
      chk_retired();
      return;
    end
    chk("exec", strobes(), 32'd0);
    if (cls == K_LW || cls == K_SW) begin
      done = 1'b0; n_rd = 0;
      for (int k = 0; k < TO && !done; k++) begin
        @(negedge clk);
        rdy = (k == wait_n);
        mem_ready = rdy;
        #1 chk("mem", strobes(), stb(0, 0, (cls == K_SW) && rdy, 0, cls == K_LW, cls == K_SW, 0));
        if (mem_read) n_rd++;
        done = rdy;
      end
      if (!done) begin
        hold_trap(2);
        return;
      end
      if (cls == K_SW) begin
        exp_retired++;
        chk_retired();
        return;
      end
      chk("mem_rd_cycles", n_rd, wait_n + 1);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("wb", strobes(), stb(0, 1, 1, 0, 0, 0, cls == K_LW));
    chk("reg_dst_rd", {31'd0, reg_dst_rd}, rd);
    exp_retired++;
    chk_retired();
  endtask

  task automatic abort_in_mem();
    @(negedge clk);
    instr_valid = 1'b1; opcode = 6'h23; funct = 6'h00; mem_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 chk("abort_mem", strobes(), stb(0, 0, 0, 0, 1, 0, 0));
    end
    #1 reset = 1'b1;
    #1 chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
    chk("abort_outs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("abort_idle", strobes(), 32'd0);
    end
    chk_retired();
  endtask

  initial begin
    int p, w;
    logic [5:0] rop, rfn;
    for (int i = 0; i < 64; i++) begin
      r_op[i] = -1; r_in2[i] = 0; i_op[i] = -1; i_in1[i] = 0; i_cls[i] = K_ALU;
    end
    for (int i = 0; i < 16; i++) begin
      r_op[r_fn_list[i]] = r_op_list[i]; r_in2[r_fn_list[i]] = r_in2_list[i];
    end
    for (int i = 0; i < 12; i++) begin
      i_op[i_opc_list[i]] = i_op_list[i]; i_in1[i_opc_list[i]] = i_in1_list[i];
      i_cls[i_opc_list[i]] = i_cls_list[i];
    end

    reset = 1'b1; instr_valid = 1'b1; opcode = 6'h00; funct = 6'h20;
    zero_flag = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b0;

    run_instr(6'h00, 6'h20, 0, 1'b0);
    run_instr(6'h0F, 6'h11, 0, 1'b0);
    run_instr(6'h0A, 6'h00, 0, 1'b0);
    run_instr(6'h00, 6'h03, 0, 1'b0);
    run_instr(6'h04, 6'h00, 0, 1'b1);
    run_instr(6'h05, 6'h00, 0, 1'b1);
    run_instr(6'h23, 6'h00, 5, 1'b0);
    run_instr(6'h2B, 6'h00, 0, 1'b0);
    run_instr(6'h2B, 6'h00, -1, 1'b0);
    run_instr(6'h3F, 6'h00, 0, 1'b0);
    run_instr(6'h00, 6'h01, 0, 1'b0);
    abort_in_mem();
    run_instr(6'h00, 6'h2A, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      p = $urandom_range(0, 99);
      if (p < 8) begin
        rop = 6'($urandom_range(0, 63)); rfn = 6'($urandom_range(0, 63));
      end else if (p < 50) begin
        rop = 6'h00; rfn = 6'(r_fn_list[$urandom_range(0, 15)]);
      end else begin
        rop = 6'(i_opc_list[$urandom_range(0, 11)]); rfn = 6'($urandom_range(0, 63));
      end
      w = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, TO - 1);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        @(negedge clk);
        instr_valid = 1'b0;
        #1 chk("idle", strobes(), 32'd0);
      end
      run_instr(rop, rfn, w, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
